// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: freezes the pipeline for LATENCY cycles, then commits one load/store.
// Optional misaligned-access detection is enabled with `define DM_RESP_ALIGN_CHECK_EN.
module dm_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_r,
  input  logic        Mem_w,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Mem_w_data,
  output logic [31:0] Mem_r_data,
  output logic        Mem_stall,
  output logic        Mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            req;
  logic            commit;
  logic            misaligned;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            unused_addr;

  assign req = Mem_r | Mem_w;
  assign idx = Mem_addr[AW+1:2];
  assign unused_addr = ^{Mem_addr[31:AW+2], Mem_addr[1:0]};

`ifdef DM_RESP_ALIGN_CHECK_EN
  assign misaligned = |Mem_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The access is committed on the edge that enters DONE, so DONE never re-accepts.
  assign commit = (state != DONE) && (state_nxt == DONE);

  // Stall is dropped while reset is held so the pipeline is never frozen by a dead access.
  assign Mem_stall = rst_n & (((state == IDLE) & req) | (state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      Mem_r_data <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit && Mem_w && !misaligned) mem[idx] <= Mem_w_data;
      if (commit && Mem_r && !Mem_w) Mem_r_data <= misaligned ? 32'h0 : mem[idx];
    end
  end

`ifdef DM_RESP_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= commit & misaligned;
  end

  assign Mem_err = err_q;
`else
  assign Mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: stall timing, load/store data, wrap, alignment and async reset.
module tb_dm_responder;

  localparam int DEPTH_WORDS = 64;
  localparam int LATENCY     = 2;

  logic        clk;
  logic        rst_n;
  logic        Mem_r;
  logic        Mem_w;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_w_data;
  logic [31:0] Mem_r_data;
  logic        Mem_stall;
  logic        Mem_err;

  int errors = 0;
  int checks = 0;

  dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Mem_r      (Mem_r),
    .Mem_w      (Mem_w),
    .Mem_addr   (Mem_addr),
    .Mem_w_data (Mem_w_data),
    .Mem_r_data (Mem_r_data),
    .Mem_stall  (Mem_stall),
    .Mem_err    (Mem_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: drive at a negedge, check stall through the wait cycles, then check DONE outputs.
  task automatic access(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    @(negedge clk);
    Mem_r      = r;
    Mem_w      = w;
    Mem_addr   = addr;
    Mem_w_data = wdata;
    #1 check({tag, "_stall_accept"}, Mem_stall, 1);
    for (int i = 1; i < LATENCY; i++) begin
      @(negedge clk);
      #1 check({tag, "_stall_busy"}, Mem_stall, 1);
      check({tag, "_err_busy"}, Mem_err, 0);
    end
    @(negedge clk);
    #1 check({tag, "_stall_done"}, Mem_stall, 0);
    check({tag, "_rdata_done"}, Mem_r_data, exp_rd);
    check({tag, "_err_done"}, Mem_err, exp_err);
  endtask

  task automatic idle();
    @(negedge clk);
    Mem_r = 1'b0;
    Mem_w = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    Mem_r      = 1'b0;
    Mem_w      = 1'b0;
    Mem_addr   = '0;
    Mem_w_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("reset_stall", Mem_stall, 0);
    check("reset_rdata", Mem_r_data, 0);
    check("reset_err", Mem_err, 0);

    // load from fresh memory
    access(1, 0, 32'h10, 32'h0, 32'h0, 0, "ld10");

    // store then load same address
    access(0, 1, 32'h08, 32'hDEADBEEF, 32'h0, 0, "st08");
    access(1, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "ld08");

    // back-to-back stores and loads, 3-cycle cadence
    access(0, 1, 32'h00, 32'h11111111, 32'hDEADBEEF, 0, "st00");
    access(0, 1, 32'h04, 32'h22222222, 32'hDEADBEEF, 0, "st04");
    access(1, 0, 32'h00, 32'h0, 32'h11111111, 0, "ld00");
    access(1, 0, 32'h04, 32'h0, 32'h22222222, 0, "ld04");

    // both strobes high: store wins, load data unchanged
    access(1, 1, 32'h04, 32'h33333333, 32'h22222222, 0, "rw04");
    access(1, 0, 32'h04, 32'h0, 32'h33333333, 0, "ld04b");

    // address wrap: 0x100 aliases word 0
    access(0, 1, 32'h100, 32'h00001234, 32'h33333333, 0, "st100");
    access(1, 0, 32'h000, 32'h0, 32'h00001234, 0, "ldwrap");
    idle();

`ifdef DM_RESP_ALIGN_CHECK_EN
    access(0, 1, 32'h1A, 32'h00005555, 32'h00001234, 1, "stmis");
    idle();
    #1 check("err_after_done", Mem_err, 0);
    access(1, 0, 32'h18, 32'h0, 32'h0, 0, "ld18");
    access(1, 0, 32'h19, 32'h0, 32'h0, 1, "ldmis");
`else
    access(0, 1, 32'h1A, 32'h00005555, 32'h00001234, 0, "stmis");
    idle();
    #1 check("err_after_done", Mem_err, 0);
    access(1, 0, 32'h18, 32'h0, 32'h00005555, 0, "ld18");
    access(1, 0, 32'h19, 32'h0, 32'h00005555, 0, "ldmis");
`endif
    idle();

    // async reset during BUSY of a store; request already present at release
    @(negedge clk);
    Mem_r      = 1'b0;
    Mem_w      = 1'b1;
    Mem_addr   = 32'h0C;
    Mem_w_data = 32'h000000AA;
    #1 check("rst_st_accept", Mem_stall, 1);
    @(negedge clk);
    #1 check("rst_st_busy", Mem_stall, 1);
    rst_n = 1'b0;
    #1 check("rst_stall_drop", Mem_stall, 0);
    check("rst_rdata_clear", Mem_r_data, 0);
    Mem_r = 1'b1;
    Mem_w = 1'b0;
    @(negedge clk);
    #1 check("rst_held_stall", Mem_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release_stall", Mem_stall, 1);
    @(negedge clk);
    #1 check("rst_ld_busy", Mem_stall, 1);
    @(negedge clk);
    #1 check("rst_ld_done_stall", Mem_stall, 0);
    check("rst_ld0c_rdata", Mem_r_data, 0);

    // memory cleared by reset
    access(1, 0, 32'h08, 32'h0, 32'h0, 0, "ld08_cleared");
    idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
